video_adapter: RTL and testbench

- Parametrised next-generation VGA display controller with an 80-column text mode and a 320x200 8bpp graphics mode.
- Generates sync and 12-bit RGB, and fetches character/attribute and pixel bytes from shared video RAM through a 1-cycle synchronous read port. Fetches font rows from font ROM.
- Adds four things: a per-frame latched start address for hardware scroll, a programmable cursor shape, an attribute-blink mode, and a vblank strobe for the CPU side.

---
 rtl/video_adapter.sv | 176 +++++++++++++++++
 tb/tb_video_adapter.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/video_adapter.sv
// VGA text/graphics controller. Registered outputs track the X/Y counters with zero lag.
// Sync/colour are registered; video RAM and font ROM are read through 1-cycle synchronous ports.
module video_adapter #(
    parameter int          H_BACK    = 48,
    parameter int          H_VIS     = 640,
    parameter int          H_FRONT   = 16,
    parameter int          H_SYNC    = 96,
    parameter int          V_BACK    = 35,
    parameter int          V_VIS     = 400,
    parameter int          V_FRONT   = 12,
    parameter int          V_SYNC    = 2,
    parameter logic [15:0] TEXT_BASE = 16'h8000,
    parameter int          COLS      = 80,
    parameter int          BLINK_DIV = 12500000
) (
    input  logic        clock,
    input  logic        reset,
    output logic [3:0]  r,
    output logic [3:0]  g,
    output logic [3:0]  b,
    output logic        hs,
    output logic        vs,
    output logic        vblank,
    input  logic        videomode,
    input  logic [11:0] start_addr,
    input  logic [11:0] cursor,
    input  logic [3:0]  cur_start,
    input  logic [3:0]  cur_end,
    input  logic        cur_en,
    input  logic        blink_en,
    output logic [15:0] video_a,
    input  logic [7:0]  video_q,
    output logic [11:0] font_a,
    input  logic [7:0]  font_q
);
    localparam int          HW       = H_BACK + H_VIS + H_FRONT + H_SYNC;
    localparam int          VW       = V_BACK + V_VIS + V_FRONT + V_SYNC;
    localparam logic [11:0] HB       = 12'(H_BACK);
    localparam logic [11:0] HV       = 12'(H_VIS);
    localparam logic [11:0] HS_END   = 12'(H_BACK + H_VIS + H_FRONT);
    localparam logic [11:0] HLAST    = 12'(HW - 1);
    localparam logic [11:0] VB       = 12'(V_BACK);
    localparam logic [11:0] VV       = 12'(V_VIS);
    localparam logic [11:0] VS_START = 12'(V_BACK + V_VIS + V_FRONT);
    localparam logic [11:0] VBL_LINE = 12'(V_BACK + V_VIS);
    localparam logic [11:0] VLAST    = 12'(VW - 1);
    localparam logic [11:0] COLS12   = 12'(COLS);
    localparam logic [31:0] DIV_LAST = 32'(BLINK_DIV - 1);

    logic [11:0] x_q, x_d, y_q, y_d;
    logic [31:0] timer_q, timer_d;
    logic        flash_q, flash_d;
    logic        mode_q;
    logic [11:0] start_q;
    logic [7:0]  row_q, attr_q;
    logic [11:0] font_hold_q;
    logic [15:0] video_a_q, video_a_d;
    logic [11:0] rgb_q, rgb_d;
    logic        hs_q, vs_q, vblank_q;

    logic        ndisp, nvis_row, cvis_row, mask;
    logic [11:0] npx, nfx, ngx, cfx, pix_at, fetch_at, trgb, grgb;
    logic [9:0]  npy;
    logic [3:0]  scan_n, cscan, tcol;
    logic [7:0]  cell_bits, cell_attr;

    function automatic logic [11:0] cmap(input logic [3:0] c);
        if (c == 4'd0)
            return 12'h111;
        else if (c == 4'd7)
            return 12'hCCC;
        else
            return {c[2], {3{c[3]}}, c[1], {3{c[3]}}, c[0], {3{c[3]}}};
    endfunction

    always_comb begin
        x_d = (x_q == HLAST) ? 12'd0 : x_q + 12'd1;
        y_d = y_q;
        if (x_q == HLAST)
            y_d = (y_q == VLAST) ? 12'd0 : y_q + 12'd1;

        timer_d = timer_q + 32'd1;
        flash_d = flash_q;
        if (timer_q == DIV_LAST) begin
            timer_d = 32'd0;
            flash_d = ~flash_q;
        end

        // Everything below describes the pixel that becomes visible next cycle.
        nvis_row = (y_d >= VB) && (y_d < VB + VV);
        ndisp    = nvis_row && (x_d >= HB) && (x_d < HB + HV);
        npx      = x_d - HB;
        npy      = 10'(y_d - VB);
        scan_n   = npy[3:0];

        // Cell row/attr land on the last clock of the previous cell, so bypass them.
        cell_bits = (npx[2:0] == 3'd0) ? font_q  : row_q;
        cell_attr = (npx[2:0] == 3'd0) ? video_q : attr_q;
        pix_at    = start_q + 12'(npy[8:4]) * COLS12 + 12'(npx[11:3]);
        mask      = cell_bits[~npx[2:0]];
        if (blink_en && cell_attr[7] && !flash_d)
            mask = 1'b0;
        if (cur_en && flash_d && (pix_at == cursor) && (cur_start <= scan_n) && (scan_n <= cur_end))
            mask = 1'b1;
        tcol = mask ? cell_attr[3:0] : (blink_en ? {1'b0, cell_attr[6:4]} : cell_attr[7:4]);
        trgb = cmap(tcol);
        grgb = {video_q[7:5], video_q[7], video_q[4:2], video_q[4], video_q[1:0], video_q[1:0]};
        rgb_d = !ndisp ? 12'h000 : (mode_q ? grgb : trgb);

        // Text fetch runs one cell ahead; graphics fetch runs two pixels ahead.
        nfx       = x_d + 12'd8 - HB;
        ngx       = x_d + 12'd2 - HB;
        fetch_at  = start_q + 12'(npy[8:4]) * COLS12 + 12'(nfx[11:3]);
        video_a_d = video_a_q;
        if (!mode_q && nvis_row && (nfx < HV)) begin
            if (nfx[2:0] == 3'd5)
                video_a_d = TEXT_BASE + {3'b000, fetch_at, 1'b0};
            else if (nfx[2:0] == 3'd6)
                video_a_d[0] = 1'b1;
        end else if (mode_q && nvis_row && (ngx < HV)) begin
            video_a_d = 16'(npy[9:1]) * 16'd320 + 16'(ngx[11:1]);
        end

        // Font address follows the char byte combinationally while it is on video_q.
        cvis_row = (y_q >= VB) && (y_q < VB + VV);
        cfx      = x_q + 12'd8 - HB;
        cscan    = 4'(y_q - VB);
        font_a   = font_hold_q;
        if (!mode_q && cvis_row && (cfx < HV) && (cfx[2:0] == 3'd6))
            font_a = {video_q, cscan};
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            x_q         <= '0;
            y_q         <= '0;
            timer_q     <= '0;
            flash_q     <= 1'b0;
            mode_q      <= 1'b0;
            start_q     <= '0;
            row_q       <= '0;
            attr_q      <= '0;
            font_hold_q <= '0;
            video_a_q   <= '0;
            rgb_q       <= '0;
            hs_q        <= 1'b1;
            vs_q        <= 1'b0;
            vblank_q    <= 1'b0;
        end else begin
            x_q         <= x_d;
            y_q         <= y_d;
            timer_q     <= timer_d;
            flash_q     <= flash_d;
            font_hold_q <= font_a;
            video_a_q   <= video_a_d;
            rgb_q       <= rgb_d;
            hs_q        <= (x_d < HS_END);
            vs_q        <= (y_d >= VS_START);
            vblank_q    <= (x_d == 12'd0) && (y_d == VBL_LINE);
            if (x_q == 12'd0 && y_q == 12'd0) begin
                mode_q  <= videomode;
                start_q <= start_addr;
            end
            if (npx[2:0] == 3'd0) begin
                row_q  <= font_q;
                attr_q <= video_q;
            end
        end
    end

    assign {r, g, b} = rgb_q;
    assign hs        = hs_q;
    assign vs        = vs_q;
    assign vblank    = vblank_q;
    assign video_a   = video_a_q;
endmodule

// File: tb/tb_video_adapter.sv
// Bench for video_adapter: small timing, random RAM/font contents, reference model of the display rules.
module tb_video_adapter;
    localparam int HB = 8, HV = 48, HF = 4, HSY = 6;
    localparam int VB = 3, VV = 34, VF = 2, VSY = 2;
    localparam int HW = HB + HV + HF + HSY;
    localparam int VW = VB + VV + VF + VSY;
    localparam int NCOLS = 6, DIV = 4;
    localparam int TBASE = 32'h8000;
    localparam int FRAME = HW * VW;

    logic        clock = 1'b0;
    logic        reset;
    logic [3:0]  r, g, b;
    logic        hs, vs, vblank;
    logic        videomode;
    logic [11:0] start_addr, cursor;
    logic [3:0]  cur_start, cur_end;
    logic        cur_en, blink_en;
    logic [15:0] video_a;
    logic [7:0]  video_q;
    logic [11:0] font_a;
    logic [7:0]  font_q;

    logic [7:0] vram [0:65535];
    logic [7:0] font [0:4095];

    int checks = 0, errors = 0;
    int t = 0;
    int dir = 0;
    logic       f_mode;
    logic [11:0] f_start;

    video_adapter #(
        .H_BACK(HB), .H_VIS(HV), .H_FRONT(HF), .H_SYNC(HSY),
        .V_BACK(VB), .V_VIS(VV), .V_FRONT(VF), .V_SYNC(VSY),
        .TEXT_BASE(16'h8000), .COLS(NCOLS), .BLINK_DIV(DIV)
    ) dut (
        .clock(clock), .reset(reset), .r(r), .g(g), .b(b),
        .hs(hs), .vs(vs), .vblank(vblank),
        .videomode(videomode), .start_addr(start_addr), .cursor(cursor),
        .cur_start(cur_start), .cur_end(cur_end), .cur_en(cur_en), .blink_en(blink_en),
        .video_a(video_a), .video_q(video_q), .font_a(font_a), .font_q(font_q)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        video_q <= vram[video_a];
        font_q  <= font[font_a];
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h (t=%0d)", tag, obs, exp, t);
        end
    endtask

    function automatic int colour(input int c);
        int hi;
        if (c == 0) return 'h111;
        if (c == 7) return 'hCCC;
        hi = ((c >> 3) & 1) * 7;
        return ((((c >> 2) & 1) * 8 + hi) << 8) + ((((c >> 1) & 1) * 8 + hi) << 4) + ((c & 1) * 8 + hi);
    endfunction

    function automatic int cell_of(input int y, input int col);
        return (f_start + (y / 16) * NCOLS + col) % 4096;
    endfunction

    function automatic int expect_rgb(input int X, input int Y, input int tt);
        int x, y, byt, at, ch, attr, bits, m, flash, scan, bg, r3, g3, b2;
        if (!(X >= HB && X < HB + HV && Y >= VB && Y < VB + VV)) return 0;
        x = X - HB;
        y = Y - VB;
        if (f_mode) begin
            byt = vram[(y / 2) * 320 + x / 2];
            r3 = byt >> 5;
            g3 = (byt >> 2) & 7;
            b2 = byt & 3;
            return ((r3 * 2 + r3 / 4) << 8) + ((g3 * 2 + g3 / 4) << 4) + b2 * 5;
        end
        at    = cell_of(y, x / 8);
        ch    = vram[TBASE + 2 * at];
        attr  = vram[TBASE + 2 * at + 1];
        scan  = y % 16;
        bits  = font[ch * 16 + scan];
        m     = (bits >> (7 - x % 8)) & 1;
        flash = (tt / DIV) % 2;
        if (blink_en && attr >= 128 && flash == 0) m = 0;
        if (cur_en && flash == 1 && at == cursor && cur_start <= scan && scan <= cur_end) m = 1;
        bg = blink_en ? ((attr >> 4) & 7) : (attr >> 4);
        return m ? colour(attr & 15) : colour(bg);
    endfunction

    task automatic run_cycles(input int n);
        int X, Y, a;
        for (int k = 0; k < n; k++) begin
            X = t % HW;
            Y = (t / HW) % VW;
            if (X == 0 && Y == 0) begin
                f_mode  = videomode;
                f_start = start_addr;
            end
            check("rgb", {4'h0, r, g, b}, 16'(expect_rgb(X, Y, t)));
            check("sync", {13'd0, hs, vs, vblank},
                  {13'd0, 1'(X < HB + HV + HF), 1'(Y >= VB + VV + VF), 1'(X == 0 && Y == VB + VV)});
            if (Y >= VB && Y < VB + VV) begin
                if (!f_mode) begin
                    a = TBASE + 2 * cell_of(Y - VB, 0);
                    if (X == HB - 3) check("fetch_char", video_a, 16'(a));
                    if (X == HB - 2) begin
                        check("fetch_attr", video_a, 16'(a + 1));
                        check("font_a", {4'h0, font_a}, 16'(vram[a] * 16 + (Y - VB) % 16));
                    end
                end else begin
                    a = ((Y - VB) / 2) * 320;
                    if (X == HB - 2) check("gfx_addr0", video_a, 16'(a));
                    if (X == HB) check("gfx_addr1", video_a, 16'(a + 1));
                end
            end
            if (dir == 1 && Y == VB && X == HB) check("text_px0", {4'h0, r, g, b}, 16'hFF7);
            if (dir == 1 && Y == VB && X == HB + 1) check("text_px1", {4'h0, r, g, b}, 16'h008);
            if (dir == 2 && Y == VB + 1 && X == HB + 1) check("gfx_red", {4'h0, r, g, b}, 16'hF00);
            if (dir == 2 && Y == VB && X == HB + 3) check("gfx_green", {4'h0, r, g, b}, 16'h0F0);
            @(posedge clock);
            #1;
            t++;
        end
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) vram[i] = 8'($urandom);
        for (int i = 0; i < 4096; i++) font[i] = 8'($urandom);
        reset = 1'b1; videomode = 1'b0; start_addr = '0; cursor = '0;
        cur_start = '0; cur_end = '0; cur_en = 1'b0; blink_en = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("rst_rgb", {4'h0, r, g, b}, 16'h0);
        check("rst_sync", {13'd0, hs, vs, vblank}, 16'b100);
        check("rst_video_a", video_a, 16'h0);
        check("rst_font_a", {4'h0, font_a}, 16'h0);
        reset = 1'b0;
        t = 0;

        // Directed text cell, then a mid-frame start_addr change.
        vram[16'h8000] = 8'h41; vram[16'h8001] = 8'h1E; font[12'h410] = 8'h80;
        dir = 1;
        run_cycles(FRAME / 2);
        start_addr = 12'd80;
        run_cycles(FRAME - FRAME / 2);
        dir = 0;
        run_cycles(FRAME);
        check("start80_fetch_latched", {4'h0, f_start}, 16'd80);

        // Cursor shape on cell 0, then an inverted (disabled) shape.
        start_addr = 0; cursor = 0; cur_start = 4'd14; cur_end = 4'd15; cur_en = 1'b1;
        run_cycles(FRAME);
        cur_start = 4'd15; cur_end = 4'd14;
        run_cycles(FRAME);

        // Blinking attribute F4h across the top row.
        cur_en = 1'b0;
        for (int i = 0; i < NCOLS; i++) vram[TBASE + 2 * i + 1] = 8'hF4;
        blink_en = 1'b1;
        run_cycles(FRAME);
        blink_en = 1'b0;
        run_cycles(FRAME);

        // Graphics mode.
        vram[0] = 8'hE0; vram[1] = 8'h1C;
        videomode = 1'b1; dir = 2;
        run_cycles(FRAME);
        dir = 0;

        for (int f = 0; f < 4; f++) begin
            videomode  = 1'($urandom);
            start_addr = 12'($urandom_range(0, 4095));
            cursor     = 12'(start_addr + 12'($urandom_range(0, 12)));
            cur_start  = 4'($urandom);
            cur_end    = 4'($urandom);
            cur_en     = 1'($urandom);
            blink_en   = 1'($urandom);
            run_cycles(FRAME);
        end

        // Reset in the middle of a frame restarts the raster.
        videomode = 1'b0; start_addr = 12'd7; cur_en = 1'b1; cursor = 12'd8;
        cur_start = 0; cur_end = 4'd15;
        run_cycles(1000);
        reset = 1'b1;
        @(posedge clock);
        #1;
        check("midrst_rgb", {4'h0, r, g, b}, 16'h0);
        check("midrst_sync", {13'd0, hs, vs, vblank}, 16'b100);
        reset = 1'b0;
        t = 0;
        run_cycles(FRAME + 100);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
